// File: rtl/sfifo_prog.sv
// sfifo_prog: single-clock FIFO with arbitrary depth, programmable
// pre_full/pre_empty thresholds, occupancy output, standard or
// first-word-fall-through read, and sticky overflow/underflow flags.
// Optional build macro SFIFO_PEAK_EN adds a peak_level output.
`timescale 1ns/1ps

module sfifo_prog #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 16,
  parameter int PRE_FULL_TH  = DEPTH - 1,
  parameter int PRE_EMPTY_TH = 1,
  parameter bit FWFT         = 1'b0
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic                         wren,
  input  logic [DATA_WIDTH-1:0]        wdata,
  output logic                         full,
  output logic                         pre_full,
  input  logic                         rden,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic                         empty,
  output logic                         pre_empty,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow,
  output logic                         underflow,
  input  logic                         err_clr
`ifdef SFIFO_PEAK_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   peak_level
`endif
);

  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [LW-1:0] PF_L     = LW'(PRE_FULL_TH);
  localparam logic [LW-1:0] PE_L     = LW'(PRE_EMPTY_TH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  // Reject configurations the flag logic cannot represent.
  if (DEPTH < 2) begin : g_bad_depth
    $error("sfifo_prog: DEPTH must be >= 2");
  end
  if (PRE_FULL_TH < 1 || PRE_FULL_TH > DEPTH) begin : g_bad_pf
    $error("sfifo_prog: PRE_FULL_TH out of range 1..DEPTH");
  end
  if (PRE_EMPTY_TH < 0 || PRE_EMPTY_TH > DEPTH - 1) begin : g_bad_pe
    $error("sfifo_prog: PRE_EMPTY_TH out of range 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr_nxt;
  logic [PW-1:0]         rd_ptr_nxt;
  logic [LW-1:0]         level_nxt;
  logic                  wr_acc;
  logic                  rd_acc;

  // Accept decisions, wrapping pointer increments and next occupancy.
  always_comb begin
    wr_acc     = wren & ~full;
    rd_acc     = rden & ~empty;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (wr_acc) wr_ptr_nxt = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
    if (rd_acc) rd_ptr_nxt = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
    level_nxt  = level + LW'(wr_acc) - LW'(rd_acc);
  end

  // Pointers, occupancy and all flags, the flags derived from next level.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      full      <= 1'b0;
      pre_full  <= (PRE_FULL_TH == 0);
      empty     <= 1'b1;
      pre_empty <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      level     <= level_nxt;
      full      <= (level_nxt == DEPTH_L);
      pre_full  <= (level_nxt >= PF_L);
      empty     <= (level_nxt == '0);
      pre_empty <= (level_nxt <= PE_L);
      // A fresh error in the clearing cycle keeps the flag set.
      overflow  <= (overflow & ~err_clr) | (wren & full);
      underflow <= (underflow & ~err_clr) | (rden & empty);
    end
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wdata;
  end

  if (FWFT) begin : g_fwft
    // Head entry drives rdata directly; meaningless while empty.
    assign rdata = mem[rd_ptr];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rdata_q;
    // Registered read data, updated only by an accepted read.
    always_ff @(posedge clk or posedge arst) begin
      if (arst)        rdata_q <= '0;
      else if (rd_acc) rdata_q <= mem[rd_ptr];
    end
    assign rdata = rdata_q;
  end

`ifdef SFIFO_PEAK_EN
  // High-water mark since reset or the last error clear.
  always_ff @(posedge clk or posedge arst) begin
    if (arst)                        peak_level <= '0;
    else if (err_clr)                peak_level <= level_nxt;
    else if (level_nxt > peak_level) peak_level <= level_nxt;
  end
`endif

endmodule

// File: tb/tb_sfifo_prog.sv
// Bench for sfifo_prog: two DEPTH=5 instances (standard and FWFT read)
// share one stimulus stream and are compared to a queue-based model.
`timescale 1ns/1ps

module tb_sfifo_prog;

  localparam int DW  = 8;
  localparam int DEP = 5;
  localparam int PFT = 3;
  localparam int PET = 1;

  logic          clk = 1'b0;
  logic          arst;
  logic          wren, rden, err_clr;
  logic [DW-1:0] wdata;

  logic          full_s, pre_full_s, empty_s, pre_empty_s, ovf_s, unf_s;
  logic [DW-1:0] rdata_s;
  logic [2:0]    level_s;
  logic          full_f, pre_full_f, empty_f, pre_empty_f, ovf_f, unf_f;
  logic [DW-1:0] rdata_f;
  logic [2:0]    level_f;
`ifdef SFIFO_PEAK_EN
  logic [2:0]    peak_s, peak_f;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sfifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEP), .PRE_FULL_TH(PFT),
               .PRE_EMPTY_TH(PET), .FWFT(1'b0)) u_std (
    .clk(clk), .arst(arst), .wren(wren), .wdata(wdata), .full(full_s),
    .pre_full(pre_full_s), .rden(rden), .rdata(rdata_s), .empty(empty_s),
    .pre_empty(pre_empty_s), .level(level_s), .overflow(ovf_s),
    .underflow(unf_s), .err_clr(err_clr)
`ifdef SFIFO_PEAK_EN
    , .peak_level(peak_s)
`endif
  );

  sfifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEP), .PRE_FULL_TH(PFT),
               .PRE_EMPTY_TH(PET), .FWFT(1'b1)) u_fwft (
    .clk(clk), .arst(arst), .wren(wren), .wdata(wdata), .full(full_f),
    .pre_full(pre_full_f), .rden(rden), .rdata(rdata_f), .empty(empty_f),
    .pre_empty(pre_empty_f), .level(level_f), .overflow(ovf_f),
    .underflow(unf_f), .err_clr(err_clr)
`ifdef SFIFO_PEAK_EN
    , .peak_level(peak_f)
`endif
  );

  // Reference model: contents as a queue, plus sticky flags and last read word.
  logic [DW-1:0] q[$];
  logic          m_ovf, m_unf;
  logic [DW-1:0] m_rd;
  int            m_peak;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_rd   = '0;
    m_peak = 0;
  endtask

  task automatic model_step(input logic w, input logic [DW-1:0] d,
                            input logic r, input logic c);
    bit was_full, was_empty;
    was_full  = (q.size() == DEP);
    was_empty = (q.size() == 0);
    if (r && !was_empty) m_rd = q.pop_front();
    if (w && !was_full) q.push_back(d);
    m_ovf = (w && was_full) || (m_ovf && !c);
    m_unf = (r && was_empty) || (m_unf && !c);
    if (c) m_peak = q.size();
    else if (q.size() > m_peak) m_peak = q.size();
  endtask

  task automatic compare_all();
    int n;
    n = q.size();
    chk("std level",     32'(level_s),     32'(n));
    chk("std full",      32'(full_s),      32'(n == DEP));
    chk("std empty",     32'(empty_s),     32'(n == 0));
    chk("std pre_full",  32'(pre_full_s),  32'(n >= PFT));
    chk("std pre_empty", 32'(pre_empty_s), 32'(n <= PET));
    chk("std overflow",  32'(ovf_s),       32'(m_ovf));
    chk("std underflow", 32'(unf_s),       32'(m_unf));
    chk("std rdata",     32'(rdata_s),     32'(m_rd));
    chk("fwft level",    32'(level_f),     32'(n));
    chk("fwft full",     32'(full_f),      32'(n == DEP));
    chk("fwft empty",    32'(empty_f),     32'(n == 0));
    chk("fwft overflow", 32'(ovf_f),       32'(m_ovf));
    chk("fwft underflow",32'(unf_f),       32'(m_unf));
    if (n > 0) chk("fwft rdata", 32'(rdata_f), 32'(q[0]));
`ifdef SFIFO_PEAK_EN
    chk("std peak",  32'(peak_s), 32'(m_peak));
    chk("fwft peak", 32'(peak_f), 32'(m_peak));
`endif
  endtask

  task automatic step(input logic w, input logic [DW-1:0] d,
                      input logic r, input logic c);
    wren = w; wdata = d; rden = r; err_clr = c;
    @(posedge clk);
    #1;
    model_step(w, d, r, c);
    compare_all();
  endtask

  task automatic do_reset();
    wren = 1'b0; rden = 1'b0; err_clr = 1'b0; wdata = '0;
    arst = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
    chk("rst level",     32'(level_s),     32'd0);
    chk("rst empty",     32'(empty_s),     32'd1);
    chk("rst pre_empty", 32'(pre_empty_s), 32'd1);
    chk("rst full",      32'(full_s),      32'd0);
    chk("rst pre_full",  32'(pre_full_s),  32'd0);
    chk("rst overflow",  32'(ovf_s),       32'd0);
    chk("rst underflow", 32'(unf_s),       32'd0);
    chk("rst rdata",     32'(rdata_s),     32'd0);
    arst = 1'b0;
  endtask

  typedef struct {
    logic          w;
    logic [DW-1:0] d;
    logic          r;
    logic          c;
    int            lvl;
    logic          full, empty, pf, pe, ovf, unf;
    logic [DW-1:0] rd;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // w    d      r     c     lvl full  empty pf    pe    ovf   unf   rdata
    tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 8'h12, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 8'h13, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 8'h14, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[4]  = '{1'b1, 8'h15, 1'b0, 1'b0, 5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[5]  = '{1'b1, 8'h66, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h12};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h13};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h14};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h15};
    tbl[11] = '{1'b1, 8'h77, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h15};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h77};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h77};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h77};

    do_reset();

    // Directed table: fill, overflow under read, clear, drain, underflow.
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].w, tbl[i].d, tbl[i].r, tbl[i].c);
      chk($sformatf("tbl%0d level", i),     32'(level_s),     32'(tbl[i].lvl));
      chk($sformatf("tbl%0d full", i),      32'(full_s),      32'(tbl[i].full));
      chk($sformatf("tbl%0d empty", i),     32'(empty_s),     32'(tbl[i].empty));
      chk($sformatf("tbl%0d pre_full", i),  32'(pre_full_s),  32'(tbl[i].pf));
      chk($sformatf("tbl%0d pre_empty", i), 32'(pre_empty_s), 32'(tbl[i].pe));
      chk($sformatf("tbl%0d overflow", i),  32'(ovf_s),       32'(tbl[i].ovf));
      chk($sformatf("tbl%0d underflow", i), 32'(unf_s),       32'(tbl[i].unf));
      chk($sformatf("tbl%0d rdata", i),     32'(rdata_s),     32'(tbl[i].rd));
    end

    // Pointer wrap across non-power-of-2 boundaries: 3 in, 3 out, four times.
    do_reset();
    for (int rep = 0; rep < 4; rep++) begin
      for (int k = 0; k < 3; k++) step(1'b1, 8'(8'h30 + rep * 8 + k), 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("wrap rdata", 32'(rdata_s), 32'(8'h30 + rep * 8 + k));
      end
    end
    chk("wrap final level", 32'(level_s), 32'd0);

    // FWFT: written word appears without rden, then reset mid-burst.
    do_reset();
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("fwft fall-through", 32'(rdata_f), 32'hA5);
    chk("fwft not empty",    32'(empty_f), 32'd0);
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    step(1'b1, 8'h3C, 1'b1, 1'b0);
    #2;
    arst = 1'b1;
    #1;
    model_clear();
    chk("midrst fwft empty", 32'(empty_f), 32'd1);
    chk("midrst fwft level", 32'(level_f), 32'd0);
    chk("midrst std empty",  32'(empty_s), 32'd1);
    chk("midrst std level",  32'(level_s), 32'd0);
    @(posedge clk);
    #1;
    arst = 1'b0;
    wren = 1'b0; rden = 1'b0;
    compare_all();

    // Randomised traffic in write-heavy, read-heavy and balanced phases.
    for (int i = 0; i < 450; i++) begin
      int wp, rp;
      wp = (i < 150) ? 75 : (i < 300) ? 25 : 50;
      rp = 100 - wp;
      step(1'($urandom_range(0, 99) < wp), 8'($urandom),
           1'($urandom_range(0, 99) < rp), 1'($urandom_range(0, 99) < 6));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
